uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter and the successor to the fixed 8N1 transmitter. Data width, parity mode, stop-bit count and baud divisor are compile-time configurable. Adds a one-cycle tx_done pulse and back-to-back frame support with no idle gap. Sits between a byte-producing controller or FIFO and the board TX pin; serial line idles high and sends LSB first.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range >= 2
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
tx_start  input  1  request to send; sampled every rising edge
data  input  DATA_BITS  frame payload; sampled only on the accept edge
uarttx  output  1  serial line; idle/stop = 1, start = 0
tx_busy  output  1  high while a frame is in flight
tx_done  output  1  single-cycle pulse at frame completion

Behaviour:
- Reset (rst_n low, asynchronous): uarttx=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0. Reset asserted mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- All outputs are registered.
- Accept: on a rising edge with tx_start=1 and tx_busy=0, data is latched into the shift register.
  - From the next cycle: tx_busy=1 and uarttx=0 (start bit).
  - tx_start while tx_busy=1 is ignored and not queued.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - PARITY is skipped when PARITY=0.
  - Each bit is held exactly CLKS_PER_BIT cycles. A baud counter runs 0..CLKS_PER_BIT-1, wraps to 0 and advances the state or bit index.
  - DATA sends data[0] first, then data[1] .. data[DATA_BITS-1]. The bit index counter is ceil(log2(DATA_BITS)) bits wide.
  - Parity bit = XOR of the latched data bits; inverted for odd parity. The parity bit makes the count of ones in data+parity odd (PARITY=1) or even (PARITY=2).
  - STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, counted from the first start-bit cycle to the last stop-bit cycle inclusive.
- Completion: on the edge ending the last stop-bit cycle, tx_done=1 for exactly one cycle and tx_busy=0 in that same cycle.
- Back-to-back: tx_start=1 in the tx_done cycle is accepted. The next start bit begins the following cycle, so the line never shows extra idle beyond the stop bits.
- data may change freely after the accept edge; the frame in flight is unaffected.
- tx_start held high continuously transmits frames back-to-back, re-sampling data at each accept.
- Illegal parameter values are not supported; the implementation may use an initial-block $error for them in simulation.

Test Plan:
1. CLKS_PER_BIT=4, 8N1, data=8'h55, tx_start pulsed 1 cycle -> uarttx shows 0,1,0,1,0,1,0,1,0,1, each 4 cycles; tx_busy high 40 cycles; tx_done pulses once at cycle 40; line then stays 1.
2. PARITY=2 (even), data=8'hE1 (four ones) -> parity bit 0; PARITY=1 (odd), data=8'hF0 -> parity bit 1; frame = 11 bits = 44 cycles.
3. STOP_BITS=2, DATA_BITS=7, data=7'h41 -> bits 0,1,0,0,0,0,0,1 then stop high 8 cycles; tx_busy high 40 cycles.
4. tx_start pulsed at cycles 5, 10 and 20 of a frame in flight (data=8'hF0, then 8'h0F) -> pulses ignored; only the 8'hF0 frame is sent, exactly once.
5. tx_start asserted in the tx_done cycle with data=8'hA5 -> the next start bit begins the following cycle; the decoded second byte is 8'hA5.
6. rst_n asserted low at cycle 17 of a frame (asynchronous, between edges) -> uarttx=1 and tx_busy=0 immediately. After release, a fresh tx_start with 8'h3C produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_param_if.sv
// Byte-side handshake and serial outputs of the parametrised UART transmitter.
// The controller (or FIFO) uses the master view and the transmitter uses the slave view.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 tx_start;
  logic [DATA_BITS-1:0] data;
  logic                 uarttx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_start,
    output data,
    input  uarttx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  data,
    output uarttx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// All outputs are registered; a frame may be accepted again in the tx_done cycle.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_param_if.slave  bus
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q,   state_d;
  logic [BW-1:0]        baud_q,    baud_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 uarttx_q,  uarttx_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;

  logic bit_wrap;
  assign bit_wrap = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    uarttx_d  = uarttx_q;
    tx_busy_d = tx_busy_q;
    tx_done_d = 1'b0;
    baud_d    = (state_q == S_IDLE || bit_wrap) ? '0 : baud_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        bit_idx_d = '0;
        if (bus.tx_start && !tx_busy_q) begin
          shift_d   = bus.data;
          // Odd parity is the inverted even parity of the payload.
          par_bit_d = (^bus.data) ^ (PARITY == 1);
          state_d   = S_START;
          uarttx_d  = 1'b0;
          tx_busy_d = 1'b1;
        end
      end
      S_START: begin
        if (bit_wrap) begin
          state_d   = S_DATA;
          uarttx_d  = shift_q[0];
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_wrap) begin
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            if (PARITY != 0) begin
              state_d  = S_PARITY;
              uarttx_d = par_bit_q;
            end else begin
              state_d  = S_STOP;
              uarttx_d = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            uarttx_d  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_wrap) begin
          state_d   = S_STOP;
          uarttx_d  = 1'b1;
          bit_idx_d = '0;
        end
      end
      S_STOP: begin
        if (bit_wrap) begin
          // Stop bits reuse the bit index as their own counter.
          if (bit_idx_q == STOP_LAST) begin
            state_d   = S_IDLE;
            uarttx_d  = 1'b1;
            tx_busy_d = 1'b0;
            tx_done_d = 1'b1;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        uarttx_d  = 1'b1;
        tx_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      uarttx_q  <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      uarttx_q  <= uarttx_d;
      tx_busy_q <= tx_busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign bus.uarttx  = uarttx_q;
  assign bus.tx_busy = tx_busy_q;
  assign bus.tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations checked every cycle against a frame-list model,
// plus table-driven frame decoding and hand-written sequences for the multi-cycle corner cases.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [4:0] start_drv;
  logic [8:0] data_drv [5];
  logic [4:0] line_v, busy_v, done_v;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Configurations: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 7N2 (all 4 clk/bit), 4 = 9E2 at 3 clk/bit
  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(8)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();
  uart_tx_param_if #(.DATA_BITS(7)) if3 ();
  uart_tx_param_if #(.DATA_BITS(9)) if4 ();

  assign if0.tx_start = start_drv[0];
  assign if1.tx_start = start_drv[1];
  assign if2.tx_start = start_drv[2];
  assign if3.tx_start = start_drv[3];
  assign if4.tx_start = start_drv[4];
  assign if0.data = data_drv[0][7:0];
  assign if1.data = data_drv[1][7:0];
  assign if2.data = data_drv[2][7:0];
  assign if3.data = data_drv[3][6:0];
  assign if4.data = data_drv[4];
  assign line_v = {if4.uarttx,  if3.uarttx,  if2.uarttx,  if1.uarttx,  if0.uarttx};
  assign busy_v = {if4.tx_busy, if3.tx_busy, if2.tx_busy, if1.tx_busy, if0.tx_busy};
  assign done_v = {if4.tx_done, if3.tx_done, if2.tx_done, if1.tx_done, if0.tx_done};

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  uart_tx_param #(.CLKS_PER_BIT(3), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  function automatic int cfg_cpb(int k);
    return (k == 4) ? 3 : 4;
  endfunction
  function automatic int cfg_db(int k);
    return (k == 3) ? 7 : ((k == 4) ? 9 : 8);
  endfunction
  function automatic int cfg_par(int k);
    return (k == 1 || k == 4) ? 2 : ((k == 2) ? 1 : 0);
  endfunction
  function automatic int cfg_stop(int k);
    return (k >= 3) ? 2 : 1;
  endfunction

  // Reference model: the whole frame is built as a list of line bits at accept time,
  // and the expected line is simply frame[cycle / CLKS_PER_BIT].
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        line;
    logic [7:0]  pos;
    logic [3:0]  nbits;
    logic [15:0] frame;
  } mstate_t;

  localparam mstate_t M_IDLE = '{busy: 1'b0, done: 1'b0, line: 1'b1, pos: 8'd0,
                                 nbits: 4'd0, frame: 16'd0};

  mstate_t m [5];

  function automatic mstate_t model_step(int k, mstate_t s, logic st, logic [8:0] d);
    mstate_t r;
    int ones;
    int n;
    r = s;
    r.done = 1'b0;
    if (s.busy) begin
      r.pos = s.pos + 8'd1;
      if (int'(r.pos) == int'(s.nbits) * cfg_cpb(k)) begin
        r.busy = 1'b0;
        r.done = 1'b1;
        r.line = 1'b1;
      end else begin
        r.line = s.frame[int'(r.pos) / cfg_cpb(k)];
      end
    end else if (st) begin
      r.frame = '0;
      ones = 0;
      n = 1;
      for (int i = 0; i < cfg_db(k); i++) begin
        r.frame[n] = d[i];
        if (d[i]) ones++;
        n++;
      end
      if (cfg_par(k) != 0) begin
        r.frame[n] = (cfg_par(k) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        n++;
      end
      for (int i = 0; i < cfg_stop(k); i++) begin
        r.frame[n] = 1'b1;
        n++;
      end
      r.nbits = 4'(n);
      r.busy  = 1'b1;
      r.pos   = 8'd0;
      r.line  = 1'b0;
    end else begin
      r.line = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) m[k] <= M_IDLE;
    end else begin
      for (int k = 0; k < 5; k++) m[k] <= model_step(k, m[k], start_drv[k], data_drv[k]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every wait goes through here so the model comparison runs on each falling edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("model_line%0d", k), 32'(line_v[k]), 32'(m[k].line));
        chk($sformatf("model_busy%0d", k), 32'(busy_v[k]), 32'(m[k].busy));
        chk($sformatf("model_done%0d", k), 32'(done_v[k]), 32'(m[k].done));
        if (m[k].done) $display("frame end inst %0d at %0t", k, $time);
      end
    end
  endtask

  task automatic launch(input int k, input logic [8:0] d);
    data_drv[k]  = d;
    start_drv[k] = 1'b1;
    tick();
    start_drv[k] = 1'b0;
  endtask

  typedef struct {
    int data;
    int par;
    int start_b;
    int stop_ok;
    int busy_cnt;
    int done_at;
    int first_line;
  } cap_t;

  // Called on the first frame cycle; returns on the tx_done cycle (or after a timeout).
  task automatic capture(input int k, input bit poke, output cap_t r);
    bit samp [200];
    int c;
    int cpb;
    int db;
    int np;
    cpb = cfg_cpb(k);
    db  = cfg_db(k);
    np  = (cfg_par(k) != 0) ? 1 : 0;
    c = 0;
    r.busy_cnt = 0;
    r.done_at  = -1;
    for (int i = 0; i < 200; i++) samp[i] = 1'b1;
    while (r.done_at < 0 && c < 200) begin
      samp[c] = line_v[k];
      if (busy_v[k]) r.busy_cnt++;
      if (done_v[k]) r.done_at = c;
      if (poke) begin
        if (c == 5 || c == 10 || c == 20) begin
          start_drv[k] = 1'b1;
          data_drv[k]  = 9'h00F;
        end else begin
          start_drv[k] = 1'b0;
        end
      end
      if (r.done_at < 0) begin
        tick();
        c++;
      end
    end
    r.first_line = int'(samp[0]);
    r.start_b    = int'(samp[cpb / 2]);
    r.data = 0;
    for (int j = 0; j < db; j++)
      if (samp[(1 + j) * cpb + cpb / 2]) r.data |= (1 << j);
    r.par = np ? int'(samp[(1 + db) * cpb + cpb / 2]) : -1;
    r.stop_ok = 1;
    for (int j = 0; j < cfg_stop(k); j++)
      if (!samp[(1 + db + np + j) * cpb + cpb / 2]) r.stop_ok = 0;
  endtask

  typedef struct {
    int         k;
    logic [8:0] data;
    int         exp_par;
    int         exp_cycles;
  } vec_t;

  vec_t vt [9];
  cap_t cr;
  int   busy_after;
  int   mode [5];

  initial begin
    vt[0] = '{0, 9'h055, -1, 40};
    vt[1] = '{0, 9'h000, -1, 40};
    vt[2] = '{1, 9'h0E1,  0, 44};
    vt[3] = '{1, 9'h001,  1, 44};
    vt[4] = '{2, 9'h0F0,  1, 44};
    vt[5] = '{2, 9'h007,  0, 44};
    vt[6] = '{3, 9'h041, -1, 40};
    vt[7] = '{4, 9'h1FF,  1, 39};
    vt[8] = '{4, 9'h0A3,  0, 39};

    start_drv = '0;
    for (int k = 0; k < 5; k++) data_drv[k] = '0;
    repeat (3) @(negedge clk);
    chk("reset_line", 32'(line_v), 32'h1F);
    chk("reset_busy", 32'(busy_v), 32'h00);
    chk("reset_done", 32'(done_v), 32'h00);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) begin
      launch(vt[i].k, vt[i].data);
      capture(vt[i].k, 1'b0, cr);
      chk($sformatf("vec%0d_start", i), 32'(cr.start_b), 32'd0);
      chk($sformatf("vec%0d_data", i), 32'(cr.data), 32'(vt[i].data));
      if (vt[i].exp_par >= 0)
        chk($sformatf("vec%0d_parity", i), 32'(cr.par), 32'(vt[i].exp_par));
      chk($sformatf("vec%0d_stop", i), 32'(cr.stop_ok), 32'd1);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(cr.busy_cnt), 32'(vt[i].exp_cycles));
      chk($sformatf("vec%0d_done_at", i), 32'(cr.done_at), 32'(vt[i].exp_cycles));
      $display("vector %0d inst %0d data %03h decoded %03h parity %0d busy %0d",
               i, vt[i].k, vt[i].data, cr.data, cr.par, cr.busy_cnt);
      repeat (3) tick();
    end

    // tx_start pulses during a frame are dropped, not queued
    launch(0, 9'h0F0);
    capture(0, 1'b1, cr);
    start_drv[0] = 1'b0;
    chk("ignore_data", 32'(cr.data), 32'h0F0);
    chk("ignore_done_at", 32'(cr.done_at), 32'd40);
    busy_after = 0;
    repeat (10) begin
      tick();
      if (busy_v[0] || !line_v[0]) busy_after++;
    end
    chk("ignore_no_second_frame", 32'(busy_after), 32'd0);
    $display("ignore-while-busy frame decoded %02h", cr.data);

    // Back-to-back: accept in the tx_done cycle, start bit on the very next cycle
    launch(0, 9'h012);
    capture(0, 1'b0, cr);
    chk("b2b_first_data", 32'(cr.data), 32'h012);
    launch(0, 9'h0A5);
    chk("b2b_busy_next", 32'(busy_v[0]), 32'd1);
    capture(0, 1'b0, cr);
    chk("b2b_first_line", 32'(cr.first_line), 32'd0);
    chk("b2b_data", 32'(cr.data), 32'h0A5);
    chk("b2b_done_at", 32'(cr.done_at), 32'd40);
    $display("back-to-back second frame decoded %02h", cr.data);
    repeat (3) tick();

    // Asynchronous reset mid-frame, then a clean frame
    launch(0, 9'h099);
    repeat (17) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_line", 32'(if0.uarttx), 32'd1);
    chk("async_rst_busy", 32'(if0.tx_busy), 32'd0);
    chk("async_rst_done", 32'(if0.tx_done), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    launch(0, 9'h03C);
    capture(0, 1'b0, cr);
    chk("post_rst_data", 32'(cr.data), 32'h03C);
    chk("post_rst_busy", 32'(cr.busy_cnt), 32'd40);
    chk("post_rst_done_at", 32'(cr.done_at), 32'd40);
    $display("post-reset frame decoded %02h", cr.data);
    repeat (3) tick();

    // Randomised traffic: sparse pulses, held-high and dense random tx_start per instance
    for (int blk = 0; blk < 15; blk++) begin
      for (int k = 0; k < 5; k++) mode[k] = int'($urandom_range(0, 2));
      for (int cyc = 0; cyc < 200; cyc++) begin
        for (int k = 0; k < 5; k++) begin
          data_drv[k] = 9'($urandom);
          if (mode[k] == 1)      start_drv[k] = 1'b1;
          else if (mode[k] == 0) start_drv[k] = ($urandom_range(0, 11) == 0);
          else                   start_drv[k] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 399) == 0) begin
          #2 rst_n = 1'b0;
          #1;
          chk("rand_rst_line", 32'(line_v), 32'h1F);
          chk("rand_rst_busy", 32'(busy_v), 32'h00);
          tick();
          rst_n = 1'b1;
        end
        tick();
      end
    end
    start_drv = '0;
    repeat (60) tick();
    chk("final_idle_busy", 32'(busy_v), 32'h00);
    chk("final_idle_line", 32'(line_v), 32'h1F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
